// File: rtl/instr_cache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
package instr_cache_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StFill = 1'b1
  } icache_state_e;

  // Tag width left after removing the byte, offset and index bits from a 32-bit address.
  function automatic int unsigned icache_tag_w(int unsigned num_lines, int unsigned words_per_line);
    return 32 - $clog2(num_lines) - $clog2(words_per_line) - 2;
  endfunction

endpackage

// File: rtl/instr_cache_array.sv
// Valid/tag/data storage: asynchronous read, synchronous writes, valid bits cleared on reset.
module instr_cache_array #(
  parameter int unsigned NumLines     = 16,
  parameter int unsigned WordsPerLine = 4,
  parameter int unsigned TagW         = 24
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [$clog2(NumLines)-1:0]     rd_index_i,
  input  logic [$clog2(WordsPerLine)-1:0] rd_offset_i,
  output logic                            rd_valid_o,
  output logic [TagW-1:0]                 rd_tag_o,
  output logic [31:0]                     rd_data_o,
  input  logic                            inv_en_i,
  input  logic [$clog2(NumLines)-1:0]     inv_index_i,
  input  logic                            wr_en_i,
  input  logic [$clog2(NumLines)-1:0]     wr_index_i,
  input  logic [$clog2(WordsPerLine)-1:0] wr_offset_i,
  input  logic [31:0]                     wr_data_i,
  input  logic                            tag_wr_en_i,
  input  logic [TagW-1:0]                 tag_wr_tag_i
);

  logic [NumLines-1:0] valid_q;
  logic [TagW-1:0]     tag_q  [NumLines];
  logic [31:0]         data_q [NumLines][WordsPerLine];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      if (inv_en_i) valid_q[inv_index_i] <= 1'b0;
      if (tag_wr_en_i) valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tag_wr_en_i) tag_q[wr_index_i] <= tag_wr_tag_i;
    if (wr_en_i) data_q[wr_index_i][wr_offset_i] <= wr_data_i;
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_offset_i];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with line fill over a req/ready handshake.
// Define ICACHE_STATS_EN to add saturating hit_count_o/miss_count_o ports.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int unsigned NumLines     = 16,
  parameter int unsigned WordsPerLine = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic        icache_stall_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o,
`endif
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam int unsigned OB   = $clog2(WordsPerLine);
  localparam int unsigned IB   = $clog2(NumLines);
  localparam int unsigned TagW = icache_tag_w(NumLines, WordsPerLine);

  icache_state_e  state_q, state_d;
  logic [TagW-1:0] fill_tag_q, fill_tag_d;
  logic [IB-1:0]   fill_index_q, fill_index_d;
  logic [OB-1:0]   word_cnt_q, word_cnt_d;

  logic [OB-1:0]   pc_offset;
  logic [IB-1:0]   pc_index;
  logic [TagW-1:0] pc_tag;
  logic            rd_valid;
  logic [TagW-1:0] rd_tag;
  logic [31:0]     rd_data;
  logic            hit, miss, beat, last_beat;
  logic            unused_pc;

  assign pc_offset = pc_i[OB+1:2];
  assign pc_index  = pc_i[IB+OB+1:OB+2];
  assign pc_tag    = pc_i[31:IB+OB+2];
  assign unused_pc = ^pc_i[1:0];

  assign hit       = (state_q == StIdle) && rd_valid && (rd_tag == pc_tag);
  assign miss      = (state_q == StIdle) && !hit;
  assign beat      = (state_q == StFill) && mem_ready_i;
  assign last_beat = beat && (word_cnt_q == OB'(WordsPerLine - 1));

  instr_cache_array #(
    .NumLines    (NumLines),
    .WordsPerLine(WordsPerLine),
    .TagW        (TagW)
  ) u_array (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_index_i  (pc_index),
    .rd_offset_i (pc_offset),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .inv_en_i    (miss),
    .inv_index_i (pc_index),
    .wr_en_i     (beat),
    .wr_index_i  (fill_index_q),
    .wr_offset_i (word_cnt_q),
    .wr_data_i   (mem_rdata_i),
    .tag_wr_en_i (last_beat),
    .tag_wr_tag_i(fill_tag_q)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (miss) state_d = StFill;
      StFill:  if (last_beat) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req_o      = (state_q == StFill);
    mem_addr_o     = mem_req_o ? {fill_tag_q, fill_index_q, word_cnt_q, 2'b00} : 32'h0;
    icache_stall_o = !hit;
    instr_o        = hit ? rd_data : 32'h0;
  end

  // Miss line is latched so PC movement during the fill cannot redirect it.
  always_comb begin
    fill_tag_d   = fill_tag_q;
    fill_index_d = fill_index_q;
    word_cnt_d   = word_cnt_q;
    if (miss) begin
      fill_tag_d   = pc_tag;
      fill_index_d = pc_index;
      word_cnt_d   = '0;
    end else if (beat) begin
      word_cnt_d = word_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_tag_q   <= '0;
      fill_index_q <= '0;
      word_cnt_q   <= '0;
    end else begin
      fill_tag_q   <= fill_tag_d;
      fill_index_q <= fill_index_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && (hit_count_q != 32'hFFFF_FFFF)) hit_count_d = hit_count_q + 32'd1;
    if (miss && (miss_count_q != 32'hFFFF_FFFF)) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;
`endif

endmodule
